// File: rtl/instr_loader.sv
// Serial instruction loader: assembles big-endian 32-bit words from a byte
// stream and writes them to consecutive instruction-memory addresses.
module instr_loader #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] addr_reg,  addr_next;
  logic [31:0] word_reg,  word_next;
  logic [1:0]  idx_reg,   idx_next;
  logic        error_reg, error_next;

  logic        start_ok;
  logic        xfer;
  logic [31:0] lane_word;
  logic [31:0] addr_inc;

  assign start_ok = start && (word_count != 32'd0) && (word_count <= DEPTH_W);
  assign xfer     = (state_reg == RECV) && byte_valid;
  assign addr_inc = addr_reg + 32'd1;

  // Byte index 0 lands in the most significant lane, index 3 in the least.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_IDX = 2'(3 - gi);
      assign lane_word[gi*8 +: 8] = (xfer && (idx_reg == LANE_IDX)) ?
                                    byte_in : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      addr_reg  <= '0;
      word_reg  <= '0;
      idx_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      word_reg  <= word_next;
      idx_reg   <= idx_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    word_next  = word_reg;
    idx_next   = idx_reg;
    error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = RECV;
          count_next = word_count;
          addr_next  = '0;
          word_next  = '0;
          idx_next   = '0;
        end else if (start) begin
          error_next = 1'b1;
        end
      end
      RECV: begin
        word_next = lane_word;
        if (xfer) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        addr_next = addr_inc;
        idx_next  = '0;
        state_next = (addr_inc == count_reg) ? DONE : RECV;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // All handshake and strobe outputs decode registered state only.
  assign byte_ready = (state_reg == RECV);
  assign mem_we     = (state_reg == WRITE);
  assign busy       = (state_reg == RECV) || (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  assign error      = error_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = word_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: normal loads, rejected starts,
// bubbles, mid-load reset, ignored restarts and long stalls.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  instr_loader #(.DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Log memory writes and pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      $display("write addr=%0d data=%h", mem_addr, mem_wdata);
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic do_start(input logic [31:0] cnt);
    start      = 1'b1;
    word_count = cnt;
    start_cyc  = cyc;
    tick(1);
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader has taken it.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    do begin
      rdy = byte_ready;
      tick(1);
      t++;
    end while (!rdy && t < 20);
    if (!rdy) check_eq("byte_accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 50) begin
      tick(1);
      t++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_write(input int i, input logic [31:0] a, input logic [31:0] d);
    if (wa_q.size() > i) begin
      check_eq($sformatf("waddr%0d", i), wa_q[i], a);
      check_eq($sformatf("wdata%0d", i), wd_q[i], d);
    end else begin
      check_eq($sformatf("wmissing%0d", i), 32'(wa_q.size()), 32'(i + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({tag, "_we"},    32'(mem_we),     32'd0);
    check_eq({tag, "_busy"},  32'(busy),       32'd0);
    check_eq({tag, "_done"},  32'(done),       32'd0);
    check_eq({tag, "_error"}, 32'(error),      32'd0);
  endtask

  initial begin
    logic [7:0] bytes12 [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09,
                                 8'h00, 8'h07, 8'h01, 8'h09, 8'h50, 8'h20};
    logic       vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] bytes4 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int         bi;
    int         stall_bad;

    rst_n = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // Asynchronous reset: outputs clear before any clock edge.
    check_idle_outputs("rst");
    check_eq("rst_addr",  mem_addr,  32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(3);
    check_idle_outputs("post_rst");

    // Three back-to-back words.
    clear_logs();
    do_start(32'd3);
    check_eq("t1_busy",  32'(busy),       32'd1);
    check_eq("t1_ready", 32'(byte_ready), 32'd1);
    check_eq("t1_addr0", mem_addr,        32'd0);
    for (int i = 0; i < 12; i++) send_byte(bytes12[i]);
    byte_valid = 1'b0;
    wait_done();
    check_eq("t1_done_busy", 32'(busy), 32'd0);
    tick(1);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    check_eq("t1_final_addr", mem_addr, 32'd3);
    check_eq("t1_nwrites", 32'(wa_q.size()), 32'd3);
    check_write(0, 32'd0, 32'h20080005);
    check_write(1, 32'd1, 32'h20090007);
    check_write(2, 32'd2, 32'h01095020);
    if (wc_q.size() > 0) check_eq("t1_latency", 32'(wc_q[0] - start_cyc), 32'd5);
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    tick(2);
    check_eq("t1_hold_addr", mem_addr, 32'd3);

    // Rejected starts: zero and above capacity.
    clear_logs();
    do_start(32'd0);
    check_eq("t2_err0", 32'(error), 32'd1);
    check_eq("t2_ready0", 32'(byte_ready), 32'd0);
    tick(1);
    check_eq("t2_err0_pulse", 32'(error), 32'd0);
    do_start(32'd4);
    check_eq("t2_err4", 32'(error), 32'd1);
    check_eq("t2_busy4", 32'(busy), 32'd0);
    tick(2);
    check_eq("t2_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("t2_nwrites", 32'(wa_q.size()), 32'd0);
    check_eq("t2_ready", 32'(byte_ready), 32'd0);

    // Bubbles between bytes carry junk that must not be captured.
    clear_logs();
    do_start(32'd1);
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      byte_valid = vpat[i];
      if (vpat[i]) begin
        byte_in = bytes4[bi];
        bi++;
      end else begin
        byte_in = 8'hEE;
      end
      tick(1);
    end
    byte_valid = 1'b0;
    wait_done();
    tick(1);
    check_eq("t3_nwrites", 32'(wa_q.size()), 32'd1);
    check_write(0, 32'd0, 32'hAABBCCDD);

    // Reset in the middle of the second word.
    clear_logs();
    do_start(32'd2);
    for (int i = 0; i < 6; i++) send_byte(bytes12[i]);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t4_rst");
    check_eq("t4_rst_addr",  mem_addr,  32'd0);
    check_eq("t4_rst_wdata", mem_wdata, 32'd0);
    #2 rst_n = 1'b1;
    tick(4);
    check_idle_outputs("t4_idle");
    check_eq("t4_nwrites", 32'(wa_q.size()), 32'd1);
    check_write(0, 32'd0, 32'h20080005);
    clear_logs();
    do_start(32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    byte_valid = 1'b0;
    wait_done();
    tick(1);
    check_write(0, 32'd0, 32'h11223344);

    // Start reasserted with a different count during a load.
    clear_logs();
    do_start(32'd2);
    start = 1'b1;
    word_count = 32'd1;
    for (int i = 0; i < 6; i++) send_byte(bytes12[i]);
    start = 1'b0;
    send_byte(bytes12[6]); send_byte(bytes12[7]);
    byte_valid = 1'b0;
    wait_done();
    tick(2);
    check_eq("t5_nwrites", 32'(wa_q.size()), 32'd2);
    check_write(1, 32'd1, 32'h20090007);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t5_err_cnt",  32'(err_cnt),  32'd0);

    // Long stall mid-word keeps everything frozen.
    clear_logs();
    do_start(32'd1);
    send_byte(8'h12); send_byte(8'h34);
    byte_valid = 1'b0;
    byte_in = 8'h99;
    stall_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!busy || !byte_ready || mem_we || mem_wdata !== 32'h12340000) stall_bad++;
    end
    check_eq("t6_stall_bad", 32'(stall_bad), 32'd0);
    check_eq("t6_stall_wdata", mem_wdata, 32'h12340000);
    check_eq("t6_stall_nwr", 32'(wa_q.size()), 32'd0);
    send_byte(8'h56); send_byte(8'h78);
    byte_valid = 1'b0;
    wait_done();
    tick(1);
    check_eq("t6_nwrites", 32'(wa_q.size()), 32'd1);
    check_write(0, 32'd0, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter: DEPTH, default 3, the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  load request; sampled in IDLE only.
REQ-005 SHALL have port: word_count  input  32  number of words to load; sampled with start.
REQ-006 SHALL have port: byte_in  input  8  serial instruction byte.
REQ-007 SHALL have port: byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port: byte_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port: mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port: mem_addr  output  32  word index written; this is the same index the pc presents on the read side.
REQ-011 SHALL have port: mem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port: busy  output  1  high in RECV and WRITE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when a load completes.
REQ-014 SHALL have port: error  output  1  one-cycle pulse when a start request is rejected.

Function
REQ-015 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-016 SHALL, in IDLE, move to RECV on start when 1 <= word_count <= DEPTH, latching word_count and clearing mem_addr, the byte index and the word register.
REQ-017 SHALL, in IDLE, when start arrives with word_count = 0 or word_count > DEPTH, pulse error for one cycle and stay in IDLE.
REQ-018 SHALL drive byte_ready = 1 only in RECV; a byte transfers only on a cycle where byte_valid & byte_ready.
REQ-019 SHALL assemble each word big-endian: first byte to bits [31:24], then [23:16], then [15:8], fourth byte to [7:0].
REQ-020 SHALL leave the byte index and the word register unchanged on cycles without a transfer; bubbles of any length are legal.
REQ-021 SHALL move to WRITE on the edge that accepts the 4th byte, with byte_ready = 0 in WRITE.
REQ-022 SHALL, in WRITE, assert mem_we for exactly one cycle, with mem_wdata = the assembled word and mem_addr = the current word index.
REQ-023 SHALL increment mem_addr on the edge leaving WRITE, then go to DONE if the words written equal the latched count, otherwise back to RECV with the byte index at 0.
REQ-024 SHALL, in DONE, pulse done for one cycle and return to IDLE on the next edge.
REQ-025 SHALL hold mem_addr at its final value (the latched count) after the load, until the next accepted start.
REQ-026 SHALL ignore start outside IDLE: no restart, no error.
REQ-027 SHALL keep word_count changes after the start cycle from affecting the load in progress.
REQ-028 SHALL have minimum latency from an accepted start to the first mem_we of 5 cycles (4 byte transfers plus WRITE) with byte_valid held high.
REQ-029 SHALL write words to strictly consecutive addresses 0 .. count-1 with no skips or repeats.
REQ-030 SHALL never make mem_addr >= DEPTH when mem_we = 1.
REQ-031 SHALL drive mem_we, done and error combinationally from state only (registered-state Moore outputs), with no combinational path from inputs.

Reset
REQ-032 SHALL, on rst_n low and immediately without a clock, put the block in IDLE, drive byte_ready, mem_we, busy, done and error to 0, and set mem_addr, mem_wdata, the byte index and the latched count to 0.
REQ-033 SHALL, on reset mid-load, discard any partial word with no further mem_we; an already-written word is not retracted.
REQ-034 SHALL, after rst_n rises, take no action until the first start.

Verification
REQ-035 SHALL pass: start with count=3 and bytes 20 08 00 05, 20 09 00 07, 01 09 50 20 back-to-back -> mem_we at addr 0/1/2 with 0x20080005, 0x20090007, 0x01095020, then one done pulse, busy low.
REQ-036 SHALL pass: start with count=0, and separately count=4 -> one error pulse each, byte_ready stays 0, no mem_we.
REQ-037 SHALL pass: count=1 with byte_valid toggled 1,0,0,1,1,0,1 carrying AA BB CC DD -> a single write of 0xAABBCCDD to addr 0, with bubbles causing no extra captures.
REQ-038 SHALL pass: rst_n pulsed low after 6 bytes of a count=2 load -> one write only (addr 0), then IDLE with all outputs 0; a new start with count=1 then writes addr 0.
REQ-039 SHALL pass: start reasserted, and word_count changed to 1, during a count=2 load -> the load still writes 2 words and done pulses once.
REQ-040 SHALL pass: stalled byte_valid=0 for 100 cycles in RECV -> state, byte index and outputs unchanged, busy held high.
